// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2,
    StFault  = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    FaultNone       = 2'd0,
    FaultMisaligned = 2'd1,
    FaultOutOfRange = 2'd2
  } fetch_fault_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Three free-running, wrapping 32-bit event counters with increment strobes.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_fetch_i,
  input  logic        inc_redirect_i,
  input  logic        inc_stall_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] redirect_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] fetch_cnt_d, fetch_cnt_q;
  logic [31:0] redirect_cnt_d, redirect_cnt_q;
  logic [31:0] stall_cnt_d, stall_cnt_q;

  // Next counter values: add one per strobe.
  always_comb begin
    fetch_cnt_d    = fetch_cnt_q + {31'd0, inc_fetch_i};
    redirect_cnt_d = redirect_cnt_q + {31'd0, inc_redirect_i};
    stall_cnt_d    = stall_cnt_q + {31'd0, inc_stall_i};
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      fetch_cnt_q    <= fetch_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o    = fetch_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem addressing, fetch/decode output register
// with valid/ready, redirects, sticky halt and fault capture.
// Define FETCH_PERF_EN to build the live performance counters; otherwise the
// counter ports read as zero.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr_word,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_pc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_redirect_cnt,
  output logic [31:0] perf_stall_cnt
);

  localparam logic [31:0] DepthWords = 32'(IMEM_DEPTH);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic         out_valid_d, out_valid_q;
  logic [31:0]  out_instr_d, out_instr_q;
  logic [31:0]  out_pc_d, out_pc_q;
  fetch_fault_e fault_cause_d, fault_cause_q;
  logic [31:0]  fault_pc_d, fault_pc_q;

  logic advance;
  logic pc_oor;

  assign advance = !out_valid_q || out_ready;
  assign pc_oor  = {2'b00, pc_q[31:2]} >= DepthWords;

  // RUN-state priority: halt, misaligned redirect, redirect, range fault, capture.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    fault_cause_d = fault_cause_q;
    fault_pc_d    = fault_pc_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (halt_req) begin
          state_d     = StHalted;
          out_valid_d = 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
          state_d       = StFault;
          fault_cause_d = FaultMisaligned;
          fault_pc_d    = redirect_pc;
          out_valid_d   = 1'b0;
        end else if (redirect_valid) begin
          // Flush the wrong-path instruction even if decode is stalled.
          pc_d        = redirect_pc;
          out_valid_d = 1'b0;
        end else if (advance && pc_oor) begin
          state_d       = StFault;
          fault_cause_d = FaultOutOfRange;
          fault_pc_d    = pc_q;
          out_valid_d   = 1'b0;
        end else if (advance) begin
          out_instr_d = imem_instr;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + PC_STEP;
        end
      end
      default: ;  // HALTED and FAULT are terminal
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
      fault_cause_q <= FaultNone;
      fault_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      fault_cause_q <= fault_cause_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  assign imem_addr_word = {2'b00, pc_q[31:2]};
  assign out_valid      = out_valid_q;
  assign out_instr      = out_instr_q;
  assign out_pc         = out_pc_q;
  assign halted         = (state_q == StHalted) || (state_q == StFault);
  assign fault          = (state_q == StFault);
  assign fault_cause    = fault_cause_q;
  assign fault_pc       = fault_pc_q;

`ifdef FETCH_PERF_EN
  logic in_run;
  logic inc_fetch;
  logic inc_redirect;
  logic inc_stall;

  assign in_run       = (state_q == StRun);
  assign inc_fetch    = in_run && !halt_req && !redirect_valid && advance && !pc_oor;
  assign inc_redirect = in_run && !halt_req && redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign inc_stall    = in_run && out_valid_q && !out_ready;

  fetch_perf_ctr u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .inc_fetch_i    (inc_fetch),
    .inc_redirect_i (inc_redirect),
    .inc_stall_i    (inc_stall),
    .fetch_cnt_o    (perf_fetch_cnt),
    .redirect_cnt_o (perf_redirect_cnt),
    .stall_cnt_o    (perf_stall_cnt)
  );
`else
  assign perf_fetch_cnt    = '0;
  assign perf_redirect_cnt = '0;
  assign perf_stall_cnt    = '0;
`endif

endmodule
